// File: rtl/image_scale_extract.sv
// Places a ROM-held RGB565 image at a programmable origin with 1x/2x/4x pixel replication.
// Define IMAGE_SCALE_EXTRACT_COLOR_KEY_EN to treat ROM words equal to key_color as transparent.
module image_scale_extract #(
  parameter int H_VISIBLE  = 800,
  parameter int V_VISIBLE  = 480,
  parameter int IMG_WIDTH  = 200,
  parameter int IMG_HEIGHT = 200,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int ROM_LAT    = 1
) (
  input  logic              clk_ctrl,
  input  logic              reset_n,
  input  logic [15:0]       img_hbegin,
  input  logic [15:0]       img_vbegin,
  input  logic [1:0]        scale_sel,
  input  logic [DATA_W-1:0] back_color,
  input  logic [DATA_W-1:0] key_color,
  input  logic              frame_begin,
  input  logic              disp_data_req,
  input  logic [11:0]       visible_hcount,
  input  logic [11:0]       visible_vcount,
  output logic [ADDR_W-1:0] rom_addra,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              in_image
);

  typedef enum logic {S_IDLE, S_FRAME} state_t;

  localparam logic [16:0]       HV17 = 17'(H_VISIBLE);
  localparam logic [16:0]       VV17 = 17'(V_VISIBLE);
  localparam logic [16:0]       IW17 = 17'(IMG_WIDTH);
  localparam logic [16:0]       IH17 = 17'(IMG_HEIGHT);
  localparam logic [ADDR_W-1:0] IW_A = ADDR_W'(IMG_WIDTH);

  state_t            state;
  logic [15:0]       hb_sh, vb_sh;
  logic [2:0]        scale_sh;
  logic [ADDR_W-1:0] col_idx, row_base;
  logic [1:0]        h_rep, v_rep;
  logic [ROM_LAT-1:0] win_pipe, req_pipe;
  logic              out_en;

  logic [16:0] sw, sh, h_end_raw, v_end_raw, h_end, v_end, hcnt17, vcnt17;
  logic        h_win, v_win, win, line_last, h_rep_last, v_rep_last;
  logic        win_d, key_hit, show_rom;

  // Scaled image extent, clipped against the visible area in 17 bits so large origins cannot wrap.
  always_comb begin
    sw = IW17;
    sh = IH17;
    case (scale_sh)
      3'd2: begin sw = IW17 << 1; sh = IH17 << 1; end
      3'd4: begin sw = IW17 << 2; sh = IH17 << 2; end
      default: begin sw = IW17; sh = IH17; end
    endcase
    h_end_raw = {1'b0, hb_sh} + sw;
    v_end_raw = {1'b0, vb_sh} + sh;
    h_end     = (h_end_raw > HV17) ? HV17 : h_end_raw;
    v_end     = (v_end_raw > VV17) ? VV17 : v_end_raw;
    hcnt17    = {5'd0, visible_hcount};
    vcnt17    = {5'd0, visible_vcount};
  end

  assign h_win      = (hcnt17 >= {1'b0, hb_sh}) && (hcnt17 < h_end);
  assign v_win      = (vcnt17 >= {1'b0, vb_sh}) && (vcnt17 < v_end);
  assign win        = (state == S_FRAME) && disp_data_req && h_win && v_win;
  assign line_last  = (hcnt17 == h_end - 17'd1);
  assign h_rep_last = ({1'b0, h_rep} == scale_sh - 3'd1);
  assign v_rep_last = ({1'b0, v_rep} == scale_sh - 3'd1);
  assign rom_addra  = row_base + col_idx;

  // Frame control, shadow registers and address counters; frame_begin outranks a window pixel.
  always_ff @(posedge clk_ctrl or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      hb_sh    <= '0;
      vb_sh    <= '0;
      scale_sh <= 3'd1;
      col_idx  <= '0;
      row_base <= '0;
      h_rep    <= '0;
      v_rep    <= '0;
    end else if (frame_begin) begin
      state    <= S_FRAME;
      hb_sh    <= img_hbegin;
      vb_sh    <= img_vbegin;
      case (scale_sel)
        2'd1:    scale_sh <= 3'd2;
        2'd2:    scale_sh <= 3'd4;
        default: scale_sh <= 3'd1;
      endcase
      col_idx  <= '0;
      row_base <= '0;
      h_rep    <= '0;
      v_rep    <= '0;
    end else if (win) begin
      if (line_last) begin
        col_idx <= '0;
        h_rep   <= '0;
        if (v_rep_last) begin
          v_rep    <= '0;
          row_base <= row_base + IW_A;
        end else begin
          v_rep <= v_rep + 2'd1;
        end
      end else if (h_rep_last) begin
        h_rep   <= '0;
        col_idx <= col_idx + 1'b1;
      end else begin
        h_rep <= h_rep + 2'd1;
      end
    end
  end

  // Delay the window and request flags so they line up with the ROM word for the same pixel.
  always_ff @(posedge clk_ctrl or negedge reset_n) begin
    if (!reset_n) begin
      win_pipe <= '0;
      req_pipe <= '0;
      out_en   <= 1'b0;
    end else begin
      out_en      <= 1'b1;
      win_pipe[0] <= win;
      req_pipe[0] <= disp_data_req;
      for (int i = 1; i < ROM_LAT; i++) begin
        win_pipe[i] <= win_pipe[i-1];
        req_pipe[i] <= req_pipe[i-1];
      end
    end
  end

  assign win_d = win_pipe[ROM_LAT-1];

`ifdef IMAGE_SCALE_EXTRACT_COLOR_KEY_EN
  assign key_hit = win_d && (rom_data == key_color);
`else
  logic unused_key;
  assign unused_key = ^key_color;
  assign key_hit    = 1'b0;
`endif

  assign show_rom   = win_d && !key_hit;
  assign in_image   = show_rom;
  assign disp_valid = req_pipe[ROM_LAT-1];
  assign disp_data  = !out_en ? '0 : (show_rom ? rom_data : back_color);

endmodule

// File: tb/tb_image_scale_extract.sv
// Randomised raster bench for image_scale_extract with a division-based placement model and ROM model.
module tb_image_scale_extract;

  localparam int HV  = 64;
  localparam int VV  = 40;
  localparam int IW  = 20;
  localparam int IH  = 12;
  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int LAT = 2;
  localparam logic [15:0] KEY = 16'hF81F;
`ifdef IMAGE_SCALE_EXTRACT_COLOR_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic          clk_ctrl = 1'b0;
  logic          reset_n;
  logic [15:0]   img_hbegin, img_vbegin;
  logic [1:0]    scale_sel;
  logic [DW-1:0] back_color, key_color;
  logic          frame_begin, disp_data_req;
  logic [11:0]   visible_hcount, visible_vcount;
  logic [AW-1:0] rom_addra;
  logic [DW-1:0] rom_data, disp_data;
  logic          disp_valid, in_image;

  int checks   = 0;
  int failures = 0;

  image_scale_extract #(
    .H_VISIBLE(HV), .V_VISIBLE(VV), .IMG_WIDTH(IW), .IMG_HEIGHT(IH),
    .DATA_W(DW), .ADDR_W(AW), .ROM_LAT(LAT)
  ) dut (
    .clk_ctrl(clk_ctrl), .reset_n(reset_n),
    .img_hbegin(img_hbegin), .img_vbegin(img_vbegin), .scale_sel(scale_sel),
    .back_color(back_color), .key_color(key_color),
    .frame_begin(frame_begin), .disp_data_req(disp_data_req),
    .visible_hcount(visible_hcount), .visible_vcount(visible_vcount),
    .rom_addra(rom_addra), .rom_data(rom_data),
    .disp_data(disp_data), .disp_valid(disp_valid), .in_image(in_image)
  );

  always #5 clk_ctrl = ~clk_ctrl;

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd40503 + 32'd7;
    if (a == 16'd5) return KEY;
    if ((t[15:0] ^ (a >> 2)) == KEY) return KEY ^ 16'h0001;
    return t[15:0] ^ (a >> 2);
  endfunction

  // ROM with LAT cycles of read latency
  logic [15:0] addr_pipe [LAT];
  always @(posedge clk_ctrl) begin
    addr_pipe[0] <= rom_addra;
    for (int i = 1; i < LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign rom_data = rom_word(addr_pipe[LAT-1]);

  typedef struct { bit valid; bit win; int addr; } exp_t;
  exp_t exp_q[$];
  bit   m_framed = 1'b0;
  int   m_hb = 0, m_vb = 0, m_scale = 1;

  function automatic bit model_win(int h, int v, bit req);
    int he, ve;
    he = m_hb + IW * m_scale;
    ve = m_vb + IH * m_scale;
    if (he > HV) he = HV;
    if (ve > VV) ve = VV;
    return m_framed && req && h >= m_hb && h < he && v >= m_vb && v < ve;
  endfunction

  function automatic int model_addr(int h, int v);
    return ((v - m_vb) / m_scale) * IW + (h - m_hb) / m_scale;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: record what each cycle's inputs must produce, then latch frame shadows.
  always @(posedge clk_ctrl) begin
    exp_t e;
    if (!reset_n) begin
      exp_q.delete();
      m_framed = 1'b0;
      m_hb = 0; m_vb = 0; m_scale = 1;
    end else begin
      e.valid = disp_data_req;
      e.win   = model_win(int'(visible_hcount), int'(visible_vcount), disp_data_req);
      e.addr  = e.win ? model_addr(int'(visible_hcount), int'(visible_vcount)) : 0;
      exp_q.push_back(e);
      if (frame_begin) begin
        m_framed = 1'b1;
        m_hb     = int'(img_hbegin);
        m_vb     = int'(img_vbegin);
        m_scale  = (scale_sel == 2'd1) ? 2 : (scale_sel == 2'd2) ? 4 : 1;
      end
    end
  end

  // Compare process on the falling edge
  always @(negedge clk_ctrl) begin
    exp_t e;
    bit   exp_in;
    int   exp_data;
    int   h, v;
    h = int'(visible_hcount);
    v = int'(visible_vcount);
    if (!reset_n) begin
      check_output("reset_addr",  int'(rom_addra), 0);
      check_output("reset_data",  int'(disp_data), 0);
      check_output("reset_valid", int'(disp_valid), 0);
      check_output("reset_inimg", int'(in_image), 0);
    end else begin
      if (model_win(h, v, disp_data_req))
        check_output("rom_addr", int'(rom_addra), model_addr(h, v));
      if (m_framed && m_hb == 0 && m_vb == 0 && m_scale == 2 && disp_data_req) begin
        if (h == 3 && v == 2) check_output("pin_2x_r2c3", int'(rom_addra), 21);
        if (h == 2 && v == 1) check_output("pin_2x_r1c2", int'(rom_addra), 1);
        if (h == 1 && v == 0) check_output("pin_2x_r0c1", int'(rom_addra), 0);
      end
      if (m_framed && m_hb == 50 && m_vb == 30 && m_scale == 1 && disp_data_req) begin
        if (h == 63 && v == 39) check_output("pin_clip_last", int'(rom_addra), 193);
        if (h == 50 && v == 31) check_output("pin_clip_row1", int'(rom_addra), 20);
      end
      if (m_framed && m_hb == 70 && disp_data_req)
        check_output("pin_offscreen", int'(in_image), 0);
      if (exp_q.size() >= LAT) begin
        e        = exp_q[exp_q.size() - LAT];
        exp_in   = e.win && !(KEY_EN && rom_word(16'(e.addr)) == key_color);
        exp_data = exp_in ? int'(rom_word(16'(e.addr))) : int'(back_color);
        check_output("disp_valid", int'(disp_valid), int'(e.valid));
        check_output("in_image",   int'(in_image),   int'(exp_in));
        check_output("disp_data",  int'(disp_data),  exp_data);
      end
      while (exp_q.size() > LAT) void'(exp_q.pop_front());
    end
  end

  // One frame: frame_begin pulse, full raster sweep, mid-frame origin scribble, optional reset pulse.
  task automatic apply_stimulus(input int hb, input int vb, input int sel,
                                input logic [15:0] color, input bit do_reset);
    @(posedge clk_ctrl); #1;
    frame_begin   = 1'b1;
    disp_data_req = 1'b0;
    img_hbegin    = 16'(hb);
    img_vbegin    = 16'(vb);
    scale_sel     = 2'(sel);
    back_color    = color;
    @(posedge clk_ctrl); #1;
    frame_begin = 1'b0;
    for (int v = 0; v < VV; v++) begin
      for (int h = 0; h < HV; h++) begin
        @(posedge clk_ctrl); #1;
        disp_data_req  = 1'b1;
        visible_hcount = 12'(h);
        visible_vcount = 12'(v);
        if (v == VV / 2 && h == 0) begin
          img_hbegin = 16'($urandom_range(0, 80));
          img_vbegin = 16'($urandom_range(0, 50));
          scale_sel  = 2'($urandom_range(0, 3));
        end
        if (do_reset && v == 5 && h == 20) reset_n = 1'b0;
        if (do_reset && v == 5 && h == 23) reset_n = 1'b1;
      end
    end
    repeat (4) begin
      @(posedge clk_ctrl); #1;
      disp_data_req  = 1'b0;
      visible_hcount = 12'(HV);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    img_hbegin     = '0;
    img_vbegin     = '0;
    scale_sel      = '0;
    back_color     = 16'h001F;
    key_color      = KEY;
    frame_begin    = 1'b0;
    disp_data_req  = 1'b0;
    visible_hcount = '0;
    visible_vcount = '0;
    repeat (3) @(posedge clk_ctrl);
    #1 reset_n = 1'b1;
    for (int h = 0; h < 30; h++) begin
      @(posedge clk_ctrl); #1;
      disp_data_req  = 1'b1;
      visible_hcount = 12'(h);
    end
    apply_stimulus(5, 3, 0, 16'h07E0, 1'b0);
    apply_stimulus(0, 0, 1, 16'h1234, 1'b0);
    apply_stimulus(50, 30, 0, 16'hABCD, 1'b0);
    apply_stimulus(10, 7, 2, 16'h0F0F, 1'b0);
    apply_stimulus(70, 3, 0, 16'h5555, 1'b0);
    apply_stimulus(2, 2, 3, 16'hC3C3, 1'b1);
    apply_stimulus(0, 0, 0, 16'h0001, 1'b0);
    for (int f = 0; f < 5; f++)
      apply_stimulus($urandom_range(0, 70), $urandom_range(0, 45), $urandom_range(0, 3),
                     16'($urandom), 1'b0);
    repeat (LAT + 2) @(posedge clk_ctrl);
    @(negedge clk_ctrl);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
